// File: rtl/etroc2_tmr_pkg.sv
// Shared helpers for the triplicated register path: per-bit majority vote and
// the fault-injection target encodings.
package etroc2_tmr_pkg;

  // Widest register the vote helper handles; callers size-cast in and out.
  localparam int MAX_W = 64;

  // Injection target select encodings.
  localparam logic [1:0] INJ_A   = 2'd0;
  localparam logic [1:0] INJ_B   = 2'd1;
  localparam logic [1:0] INJ_C   = 2'd2;
  localparam logic [1:0] INJ_ALL = 2'd3;

  // Per-bit two-out-of-three majority.
  function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input logic [MAX_W-1:0] c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/tmr_err_counter.sv
// Upset bookkeeping for the triplicated register: a one-cycle pulse, a sticky
// flag held until cleared, and a saturating count of disagreeing cycles.
module tmr_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mismatch,
  input  logic             err_clr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Register the disagreement flag; a clear that coincides with a new
  // disagreement leaves that disagreement recorded (sticky set, count of one).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      err_pulse  <= mismatch;
      err_sticky <= (err_sticky & ~err_clr) | mismatch;
      if (err_clr) begin
        err_cnt <= mismatch ? CNT_ONE : '0;
      end else if (mismatch && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/tmr_scrub_register.sv
// Triplicated self-scrubbing register. Three copies are refreshed every cycle
// from their own majority vote (or from a write), so a single-copy upset is
// repaired at the next edge. Raw copies are exported for remote voters.
// WIDTH is limited to etroc2_tmr_pkg::MAX_W.
module tmr_scrub_register
  import etroc2_tmr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             err_clr,
  input  logic             inj_en,
  input  logic [1:0]       inj_sel,
  input  logic [WIDTH-1:0] inj_mask,
  output logic [WIDTH-1:0] qA,
  output logic [WIDTH-1:0] qB,
  output logic [WIDTH-1:0] qC,
  output logic [WIDTH-1:0] q,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  // The three copies and their next-state nets must stay physically distinct:
  // merging or retiming them would collapse the redundancy.
  (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] copyA;
  (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] copyB;
  (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] copyC;
  (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] nextA;
  (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] nextB;
  (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] nextC;

  logic [WIDTH-1:0] voted;
  logic [WIDTH-1:0] base;
  logic             hitA;
  logic             hitB;
  logic             hitC;
  logic             mismatch;

  // Vote and disagreement detection straight from the copy flops.
  always_comb begin
    voted    = WIDTH'(maj3(MAX_W'(copyA), MAX_W'(copyB), MAX_W'(copyC)));
    mismatch = |((copyA ^ copyB) | (copyB ^ copyC));
  end

  // Per-copy next value: write data or scrubbed vote, with any injected flips
  // layered on top (a write and an injection in the same cycle both apply).
  always_comb begin
    base  = wr_en ? wr_data : voted;
    hitA  = inj_en && ((inj_sel == INJ_A) || (inj_sel == INJ_ALL));
    hitB  = inj_en && ((inj_sel == INJ_B) || (inj_sel == INJ_ALL));
    hitC  = inj_en && ((inj_sel == INJ_C) || (inj_sel == INJ_ALL));
    nextA = base ^ (hitA ? inj_mask : {WIDTH{1'b0}});
    nextB = base ^ (hitB ? inj_mask : {WIDTH{1'b0}});
    nextC = base ^ (hitC ? inj_mask : {WIDTH{1'b0}});
  end

  // Copy A register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) copyA <= RESET_VAL;
    else        copyA <= nextA;
  end

  // Copy B register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) copyB <= RESET_VAL;
    else        copyB <= nextB;
  end

  // Copy C register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) copyC <= RESET_VAL;
    else        copyC <= nextC;
  end

  assign qA = copyA;
  assign qB = copyB;
  assign qC = copyC;
  assign q  = voted;

  tmr_err_counter #(.CNT_W(CNT_W)) errCounter (
    .clk        (clk),
    .reset      (reset),
    .mismatch   (mismatch),
    .err_clr    (err_clr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

endmodule

// File: tb/tb_tmr_scrub_register.sv
// Bench for tmr_scrub_register. A second instance with a 2-bit counter shares
// all inputs so counter saturation can be observed quickly.
module tb_tmr_scrub_register;

  localparam int SB_W = 44;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       err_clr;
  logic       inj_en;
  logic [1:0] inj_sel;
  logic [7:0] inj_mask;
  logic [7:0] qA, qB, qC, q;
  logic       err_pulse, err_sticky;
  logic [7:0] err_cnt;
  logic [7:0] qA2, qB2, qC2, q2;
  logic       errPulse2, errSticky2;
  logic [1:0] errCnt2;

  int tests = 0;
  int fails = 0;

  // Reference model state: three copies, flags, counters as plain integers.
  logic [7:0] mCopy[3];
  logic       mPulse, mSticky;
  int         mCnt8, mCnt2;
  logic [SB_W-1:0] expQ[$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  tmr_scrub_register #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .err_clr(err_clr),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
    .qA(qA), .qB(qB), .qC(qC), .q(q),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  tmr_scrub_register #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .err_clr(err_clr),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
    .qA(qA2), .qB(qB2), .qC(qC2), .q(q2),
    .err_pulse(errPulse2), .err_sticky(errSticky2), .err_cnt(errCnt2)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] modelVote();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      int ones;
      ones = int'(mCopy[0][i]) + int'(mCopy[1][i]) + int'(mCopy[2][i]);
      v[i] = (ones >= 2);
    end
    return v;
  endfunction

  function automatic logic [SB_W-1:0] modelBundle();
    return {modelVote(), mCopy[0], mCopy[1], mCopy[2], mPulse, mSticky,
            8'(mCnt8), 2'(mCnt2)};
  endfunction

  function automatic logic [SB_W-1:0] dutBundle();
    return {q, qA, qB, qC, err_pulse, err_sticky, err_cnt, errCnt2};
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) mCopy[k] = 8'hA5;
    mPulse  = 1'b0;
    mSticky = 1'b0;
    mCnt8   = 0;
    mCnt2   = 0;
  endtask

  task automatic modelEdge();
    logic       disagree;
    logic [7:0] baseVal;
    disagree = !((mCopy[0] == mCopy[1]) && (mCopy[1] == mCopy[2]));
    baseVal  = wr_en ? wr_data : modelVote();
    for (int k = 0; k < 3; k++) begin
      if (inj_en && ((inj_sel == 2'd3) || (int'(inj_sel) == k)))
        mCopy[k] = baseVal ^ inj_mask;
      else
        mCopy[k] = baseVal;
    end
    mPulse  = disagree;
    mSticky = (mSticky && !err_clr) || disagree;
    if (err_clr) begin
      mCnt8 = disagree ? 1 : 0;
      mCnt2 = disagree ? 1 : 0;
    end else if (disagree) begin
      mCnt8 = (mCnt8 + 1 > 255) ? 255 : mCnt8 + 1;
      mCnt2 = (mCnt2 + 1 > 3) ? 3 : mCnt2 + 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive inputs, clock once, return at the next
  // falling edge where outputs are sampled.
  task automatic step(input logic w, input logic [7:0] wd, input logic c,
                      input logic ie, input logic [1:0] is, input logic [7:0] im);
    wr_en = w; wr_data = wd; err_clr = c; inj_en = ie; inj_sel = is; inj_mask = im;
    @(posedge clk);
    modelEdge();
    expQ.push_back(modelBundle());
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00; err_clr = 1'b0;
    inj_en = 1'b0; inj_sel = 2'd0; inj_mask = 8'h00;
    repeat (2) @(negedge clk);
    modelReset();
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL reset_q got %h want a5", q); end
    tests++; if ({qA, qB, qC} !== {3{8'hA5}}) begin fails++; $display("FAIL reset_copies got %h %h %h want a5", qA, qB, qC); end
    tests++; if ({err_pulse, err_sticky, err_cnt} !== 10'd0) begin fails++; $display("FAIL reset_flags got p=%b s=%b c=%0d want 0", err_pulse, err_sticky, err_cnt); end
    tests++; if (errCnt2 !== 2'd0) begin fails++; $display("FAIL reset_cnt2 got %0d want 0", errCnt2); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    step(1'b1, 8'h3C, 1'b0, 1'b0, 2'd0, 8'h00);
    void'(expQ.pop_front());
    tests++; if ({q, qA, qB, qC} !== {4{8'h3C}}) begin fails++; $display("FAIL write_vis got %h %h %h %h want 3c", q, qA, qB, qC); end
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL write_pulse got %b want 0", err_pulse); end
  endtask

  task automatic test_single_inject();
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h01);
    void'(expQ.pop_front());
    tests++; if (qB !== 8'h3D) begin fails++; $display("FAIL inj_qB got %h want 3d", qB); end
    tests++; if (q !== 8'h3C) begin fails++; $display("FAIL inj_q got %h want 3c", q); end
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL inj_pulse_early got %b want 0", err_pulse); end
    idle();
    void'(expQ.pop_front());
    tests++; if (qB !== 8'h3C) begin fails++; $display("FAIL scrub_qB got %h want 3c", qB); end
    tests++; if ({err_pulse, err_sticky, err_cnt} !== {1'b1, 1'b1, 8'd1}) begin fails++; $display("FAIL scrub_flags got p=%b s=%b c=%0d want 1 1 1", err_pulse, err_sticky, err_cnt); end
    idle();
    void'(expQ.pop_front());
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL pulse_width got %b want 0", err_pulse); end
  endtask

  task automatic test_all_inject();
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 8'h80);
    void'(expQ.pop_front());
    tests++; if ({q, qA, qB, qC} !== {4{8'hBC}}) begin fails++; $display("FAIL all_inj got %h %h %h %h want bc", q, qA, qB, qC); end
    idle();
    void'(expQ.pop_front());
    tests++; if (q !== 8'hBC) begin fails++; $display("FAIL all_inj_persist got %h want bc", q); end
    tests++; if ({err_pulse, err_cnt} !== {1'b0, 8'd1}) begin fails++; $display("FAIL all_inj_flags got p=%b c=%0d want 0 1", err_pulse, err_cnt); end
  endtask

  task automatic test_write_with_inject();
    step(1'b1, 8'h5A, 1'b0, 1'b1, 2'd0, 8'h0F);
    void'(expQ.pop_front());
    tests++; if ({qA, qB, qC, q} !== {8'h55, 8'h5A, 8'h5A, 8'h5A}) begin fails++; $display("FAIL wr_inj got %h %h %h %h want 55 5a 5a 5a", qA, qB, qC, q); end
    idle();
    void'(expQ.pop_front());
    tests++; if ({qA, err_pulse} !== {8'h5A, 1'b1}) begin fails++; $display("FAIL wr_inj_scrub got %h p=%b want 5a 1", qA, err_pulse); end
  endtask

  task automatic test_saturation();
    step(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
    void'(expQ.pop_front());
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 2'($urandom_range(0, 2)), 8'(1 << $urandom_range(0, 7)));
      idle();
      idle();
    end
    expQ.delete();
    tests++; if (errCnt2 !== 2'd3) begin fails++; $display("FAIL sat_cnt2 got %0d want 3", errCnt2); end
    tests++; if (err_cnt !== 8'd5) begin fails++; $display("FAIL sat_cnt8 got %0d want 5", err_cnt); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
    void'(expQ.pop_front());
    tests++; if ({errCnt2, err_cnt, err_sticky} !== 11'd0) begin fails++; $display("FAIL clr got c2=%0d c8=%0d s=%b want 0", errCnt2, err_cnt, err_sticky); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 8'h10);
    step(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
    expQ.delete();
    tests++; if ({errCnt2, err_cnt, err_sticky} !== {2'd1, 8'd1, 1'b1}) begin fails++; $display("FAIL clr_coincident got c2=%0d c8=%0d s=%b want 1 1 1", errCnt2, err_cnt, err_sticky); end
  endtask

  // Scoreboard run: random writes, injections and clears against the model.
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [SB_W-1:0] exp;
      logic [SB_W-1:0] got;
      step($urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      exp = expQ.pop_front();
      got = dutBundle();
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random_cycle_%0d got %h want %h", n, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h33);
    void'(expQ.pop_front());
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    modelReset();
    tests++; if ({q, qA, qB, qC} !== {4{8'hA5}}) begin fails++; $display("FAIL async_rst got %h %h %h %h want a5", q, qA, qB, qC); end
    tests++; if ({err_pulse, err_sticky, err_cnt, errCnt2} !== 12'd0) begin fails++; $display("FAIL async_rst_flags got p=%b s=%b c=%0d c2=%0d want 0", err_pulse, err_sticky, err_cnt, errCnt2); end
    @(negedge clk);
    reset = 1'b1;
    idle();
    void'(expQ.pop_front());
    tests++; if ({q, qA, qB, qC, err_pulse} !== {{4{8'hA5}}, 1'b0}) begin fails++; $display("FAIL post_rst got %h %h %h %h p=%b want a5 0", q, qA, qB, qC, err_pulse); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_write();
    test_single_inject();
    test_all_inject();
    test_write_with_inject();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
